divider_s_c3x2_9bits_9bits_sequential: RTL

Iterative restoring divider. It is the inverse-direction companion to the team's 9x9 fractured multiplier and uses the same operand conventions: per-operand sign select, and a HALF_1 split into a 4-bit low lane [3:0] and a 5-bit high lane [8:4]. It sits beside the multiplier in the PIRDSP datapath and serves quotient/remainder requests through a start/ready and valid/ack handshake. One quotient bit is produced per lane per clock.

---
 rtl/divider_s_c3x2_9bits_9bits_sequential.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/divider_s_c3x2_9bits_9bits_sequential.sv
// Iterative restoring divider, 9x9 full mode or two independent 4-bit/5-bit lane divisions.
// One quotient bit per lane per clock; start/ready request and valid/ack result handshake.
module divider_s_c3x2_9bits_9bits_sequential #(
    parameter int unsigned A_chop_size = 9,
    parameter int unsigned B_chop_size = 9,
    parameter int unsigned LOW_LANE_W  = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [A_chop_size-1:0] A,
    input  logic [B_chop_size-1:0] B,
    input  logic                   A_sign,
    input  logic                   B_sign,
    input  logic                   HALF_1,
    output logic                   ready,
    output logic                   valid,
    input  logic                   ack,
    output logic [A_chop_size-1:0] Q,
    output logic [A_chop_size-1:0] R,
    output logic [1:0]             div_by_zero
);

    localparam int unsigned W  = A_chop_size;
    localparam int unsigned LW = LOW_LANE_W;
    localparam int unsigned HW = A_chop_size - LOW_LANE_W;
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] N_FULL = CW'(W);
    localparam logic [CW-1:0] N_HALF = CW'(HW);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           half_q, half_d;
    logic [W-1:0]   a_q, a_d;
    logic           an0_q, an0_d, bn0_q, bn0_d, an1_q, an1_d, bn1_q, bn1_d;
    // Lane 0 serves full mode and the low lane; lane 1 is the high lane.
    logic [W-1:0]   rem0_q, rem0_d, quo0_q, quo0_d, div0_q, div0_d;
    logic [HW-1:0]  rem1_q, rem1_d, quo1_q, quo1_d, div1_q, div1_d;
    logic [W-1:0]   q_q, q_d, r_q, r_d;
    logic [1:0]     dbz_q, dbz_d;
    logic           ready_q, ready_d, valid_q, valid_d;

    logic [W:0]     t0;
    logic [HW:0]    t1;
    logic [LW-1:0]  am_lo, bm_lo, ql, rl;
    logic [HW-1:0]  am_hi, bm_hi, qh, rh;
    logic [W-1:0]   qf, rf;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            half_q  <= 1'b0;
            a_q     <= '0;
            an0_q   <= 1'b0;
            bn0_q   <= 1'b0;
            an1_q   <= 1'b0;
            bn1_q   <= 1'b0;
            rem0_q  <= '0;
            quo0_q  <= '0;
            div0_q  <= '0;
            rem1_q  <= '0;
            quo1_q  <= '0;
            div1_q  <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            a_q     <= a_d;
            an0_q   <= an0_d;
            bn0_q   <= bn0_d;
            an1_q   <= an1_d;
            bn1_q   <= bn1_d;
            rem0_q  <= rem0_d;
            quo0_q  <= quo0_d;
            div0_q  <= div0_d;
            rem1_q  <= rem1_d;
            quo1_q  <= quo1_d;
            div1_q  <= div1_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        a_d     = a_q;
        an0_d   = an0_q;
        bn0_d   = bn0_q;
        an1_d   = an1_q;
        bn1_d   = bn1_q;
        rem0_d  = rem0_q;
        quo0_d  = quo0_q;
        div0_d  = div0_q;
        rem1_d  = rem1_q;
        quo1_d  = quo1_q;
        div1_d  = div1_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;
        t0      = '0;
        t1      = '0;
        am_lo   = '0;
        bm_lo   = '0;
        am_hi   = '0;
        bm_hi   = '0;
        ql      = '0;
        rl      = '0;
        qh      = '0;
        rh      = '0;
        qf      = '0;
        rf      = '0;

        unique case (state_q)
            S_IDLE: begin
                if (start && ready_q) begin
                    state_d = S_ITER;
                    half_d  = HALF_1;
                    a_d     = A;
                    rem0_d  = '0;
                    rem1_d  = '0;
                    if (HALF_1) begin
                        cnt_d  = N_HALF;
                        an0_d  = A_sign & A[LW-1];
                        bn0_d  = B_sign & B[LW-1];
                        an1_d  = A_sign & A[W-1];
                        bn1_d  = B_sign & B[W-1];
                        am_lo  = an0_d ? -A[LW-1:0] : A[LW-1:0];
                        bm_lo  = bn0_d ? -B[LW-1:0] : B[LW-1:0];
                        am_hi  = an1_d ? -A[W-1:LW] : A[W-1:LW];
                        bm_hi  = bn1_d ? -B[W-1:LW] : B[W-1:LW];
                        // Low-lane dividend sits at the top so its MSB shifts out first.
                        quo0_d = {am_lo, {(W-LW){1'b0}}};
                        div0_d = W'(bm_lo);
                        quo1_d = am_hi;
                        div1_d = bm_hi;
                    end else begin
                        cnt_d  = N_FULL;
                        an0_d  = A_sign & A[W-1];
                        bn0_d  = B_sign & B[W-1];
                        an1_d  = 1'b0;
                        bn1_d  = 1'b0;
                        quo0_d = an0_d ? -A : A;
                        div0_d = bn0_d ? -B : B;
                        quo1_d = '0;
                        div1_d = '0;
                    end
                end
            end

            S_ITER: begin
                // Low lane finishes LW iterations before the high lane and holds.
                if (!half_q || (cnt_q > CW'(HW - LW))) begin
                    t0 = {rem0_q, quo0_q[W-1]};
                    if (t0 >= {1'b0, div0_q}) begin
                        rem0_d = W'(t0 - {1'b0, div0_q});
                        quo0_d = {quo0_q[W-2:0], 1'b1};
                    end else begin
                        rem0_d = W'(t0);
                        quo0_d = {quo0_q[W-2:0], 1'b0};
                    end
                end
                if (half_q) begin
                    t1 = {rem1_q, quo1_q[HW-1]};
                    if (t1 >= {1'b0, div1_q}) begin
                        rem1_d = HW'(t1 - {1'b0, div1_q});
                        quo1_d = {quo1_q[HW-2:0], 1'b1};
                    end else begin
                        rem1_d = HW'(t1);
                        quo1_d = {quo1_q[HW-2:0], 1'b0};
                    end
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                state_d = S_DONE;
                if (half_q) begin
                    ql = (an0_q ^ bn0_q) ? -quo0_q[LW-1:0] : quo0_q[LW-1:0];
                    rl = an0_q ? -rem0_q[LW-1:0] : rem0_q[LW-1:0];
                    qh = (an1_q ^ bn1_q) ? -quo1_q : quo1_q;
                    rh = an1_q ? -rem1_q : rem1_q;
                    dbz_d = 2'b00;
                    if (div0_q == '0) begin
                        ql       = '1;
                        rl       = a_q[LW-1:0];
                        dbz_d[0] = 1'b1;
                    end
                    if (div1_q == '0) begin
                        qh       = '1;
                        rh       = a_q[W-1:LW];
                        dbz_d[1] = 1'b1;
                    end
                    q_d = {qh, ql};
                    r_d = {rh, rl};
                end else begin
                    qf    = (an0_q ^ bn0_q) ? -quo0_q : quo0_q;
                    rf    = an0_q ? -rem0_q : rem0_q;
                    dbz_d = 2'b00;
                    if (div0_q == '0) begin
                        qf    = '1;
                        rf    = a_q;
                        dbz_d = 2'b01;
                    end
                    q_d = qf;
                    r_d = rf;
                end
            end

            S_DONE: begin
                if (ack) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
        valid_d = (state_d == S_DONE);
    end

    assign ready       = ready_q;
    assign valid       = valid_q;
    assign Q           = q_q;
    assign R           = r_q;
    assign div_by_zero = dbz_q;

endmodule
